// File: rtl/imm_extend_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe_if
//
// Handshake bundle between decode (upstream), the immediate-extension stage
// and execute (downstream).
//
//   in_valid  : upstream presents an immediate
//   in_ready  : stage can accept (registered inside the stage)
//   in_imm    : raw IN_W-bit immediate
//   in_mode   : 0 sign, 1 zero, 2 upper, 3 branch offset
//   in_tag    : sideband tag travelling with the immediate
//   out_valid : out_imm/out_tag hold a valid entry
//   out_ready : downstream accepts the presented entry
//   out_imm   : extended OUT_W-bit immediate
//   out_tag   : tag of the presented entry
//
// Modports:
//   master : the side that drives the stage (decode + execute together)
//   slave  : the extension stage itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Registered immediate-extension stage at the decode/execute boundary.
// The immediate is widened from IN_W to OUT_W bits at the input (sign, zero,
// upper or branch-offset mode) and then stored in a two-entry skid buffer:
// a main register M that drives the outputs and a skid register S that
// absorbs one extra entry when execute stalls. in_ready is a flop, so
// decode never sees a combinational path from out_ready.
//
// Ports:
//   clk       : single clock, all state changes on the rising edge
//   rst       : asynchronous, active-high reset
//   flush     : synchronous squash of every buffered entry
//   bus       : handshake bundle (slave side), see imm_extend_pipe_if
//   occupancy : number of held entries, 0..2
//
// Parameters: IN_W (>= 2), OUT_W (>= IN_W + 2), TAG_W. The interface
// instance must be built with the same widths.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_extend_pipe_if.slave    bus,
    output logic [1:0]          occupancy
);

    localparam int EXT_W = OUT_W - IN_W;

    // Widen an immediate. Branch mode drops the top two bits of the
    // sign-extended value; OUT_W >= IN_W + 2 guarantees those are copies
    // of the sign bit, so nothing is lost.
    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      mode
    );
        logic signed [OUT_W-1:0] sext;
        logic        [OUT_W-1:0] res;
        sext = {{EXT_W{imm[IN_W-1]}}, imm};
        case (mode)
            2'd0:    res = sext;
            2'd1:    res = {{EXT_W{1'b0}}, imm};
            2'd2:    res = {imm, {EXT_W{1'b0}}};
            default: res = {sext[OUT_W-3:0], 2'b00};
        endcase
        return res;
    endfunction

    // ---- stage p0: handshake qualification and extension ---------------
    logic             in_ready_r;
    logic             vld_m_p1;
    logic             vld_s_p1;
    logic [OUT_W-1:0] m_imm_p1;
    logic [TAG_W-1:0] m_tag_p1;
    logic [OUT_W-1:0] s_imm_p1;
    logic [TAG_W-1:0] s_tag_p1;

    logic             accept_p0;
    logic             pop_p0;
    logic [OUT_W-1:0] ext_imm_p0;

    assign accept_p0  = bus.in_valid && in_ready_r;
    assign pop_p0     = vld_m_p1 && bus.out_ready;
    assign ext_imm_p0 = extend_imm(bus.in_imm, bus.in_mode);

    // Next-state selection for the two registers.
    logic vld_m_n;
    logic vld_s_n;
    logic load_m_in;
    logic load_m_skid;
    logic load_s;

    always_comb begin
        vld_m_n     = vld_m_p1;
        vld_s_n     = vld_s_p1;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            // Squash wins over any accept or pop in the same cycle.
            vld_m_n = 1'b0;
            vld_s_n = 1'b0;
        end else if (pop_p0 && vld_s_p1) begin
            // Skid entry moves forward; the new entry (if any) refills S.
            load_m_skid = 1'b1;
            vld_m_n     = 1'b1;
            vld_s_n     = accept_p0;
            load_s      = accept_p0;
        end else if (pop_p0 || !vld_m_p1) begin
            // M is free this cycle (popped or already empty).
            vld_m_n   = accept_p0;
            load_m_in = accept_p0;
        end else if (!vld_s_p1) begin
            // Stalled with M full: park the new entry in S.
            vld_s_n = accept_p0;
            load_s  = accept_p0;
        end
        // Both full and no pop: in_ready is low, nothing changes.
    end

    // ---- stage p1: main/skid registers ----------------------------------
    // Control and the output-facing M data share the async reset so the
    // outputs clear immediately when rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_m_p1   <= 1'b0;
            vld_s_p1   <= 1'b0;
            in_ready_r <= 1'b1;
            m_imm_p1   <= '0;
            m_tag_p1   <= '0;
        end else begin
            vld_m_p1   <= vld_m_n;
            vld_s_p1   <= vld_s_n;
            // Registered copy of !S.valid, computed from next state so it
            // is exact in the cycle the skid fills or drains.
            in_ready_r <= !vld_s_n;
            if (load_m_skid) begin
                m_imm_p1 <= s_imm_p1;
                m_tag_p1 <= s_tag_p1;
            end else if (load_m_in) begin
                m_imm_p1 <= ext_imm_p0;
                m_tag_p1 <= bus.in_tag;
            end
        end
    end

    // S data is only meaningful while vld_s_p1 is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            s_imm_p1 <= ext_imm_p0;
            s_tag_p1 <= bus.in_tag;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = vld_m_p1;
    assign bus.out_imm   = m_imm_p1;
    assign bus.out_tag   = m_tag_p1;
    assign occupancy     = {1'b0, vld_m_p1} + {1'b0, vld_s_p1};

endmodule

// File: tb/tb_imm_extend_pipe.sv
`timescale 1ns/1ps

module tb_imm_extend_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       flush2 = 1'b0;
    logic [1:0] occupancy;
    logic [1:0] occupancy2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(8)) bi ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(20), .TAG_W(8)) bi2 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bi.slave), .occupancy(occupancy)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(8)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .bus(bi2.slave), .occupancy(occupancy2)
    );

    // Reference model: ordered list of held entries, at most two.
    longint unsigned q_imm[$];
    int              q_tag[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Extension from the arithmetic meaning of each mode.
    function automatic longint unsigned ref_ext(input longint unsigned imm, input int mode,
                                                input int inw, input int outw);
        longint          s;
        longint          r;
        longint unsigned modmask;
        modmask = (64'd1 << outw) - 1;
        if (imm >= (64'd1 << (inw - 1))) s = longint'(imm) - longint'(64'd1 << inw);
        else s = longint'(imm);
        case (mode)
            0:       r = s;
            1:       r = longint'(imm);
            2:       r = longint'(imm) * longint'(64'd1 << (outw - inw));
            default: r = s * 4;
        endcase
        return longint'(r) & modmask;
    endfunction

    task automatic compare_model();
        check("in_ready", bi.in_ready, q_imm.size() < 2);
        check("out_valid", bi.out_valid, q_imm.size() > 0);
        check("occupancy", occupancy, q_imm.size());
        if (q_imm.size() > 0) begin
            check("out_imm", bi.out_imm, q_imm[0]);
            check("out_tag", bi.out_tag, q_tag[0]);
        end
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [7:0] tag, input logic ordy, input logic fl);
        bit acc;
        bit pp;
        bi.in_valid  = v;
        bi.in_imm    = imm;
        bi.in_mode   = mode;
        bi.in_tag    = tag;
        bi.out_ready = ordy;
        flush        = fl;
        acc = v && (q_imm.size() < 2);
        pp  = ordy && (q_imm.size() > 0);
        @(posedge clk);
        if (fl) begin
            q_imm.delete();
            q_tag.delete();
        end else begin
            if (pp) begin
                void'(q_imm.pop_front());
                void'(q_tag.pop_front());
            end
            if (acc) begin
                q_imm.push_back(ref_ext(imm, mode, 16, 32));
                q_tag.push_back(tag);
            end
        end
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int popped[$];
        int next_tag;
        int full_seen;

        bi.in_valid = 0; bi.in_imm = 0; bi.in_mode = 0; bi.in_tag = 0; bi.out_ready = 1;
        bi2.in_valid = 0; bi2.in_imm = 0; bi2.in_mode = 0; bi2.in_tag = 0; bi2.out_ready = 1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bi.out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", bi.in_ready, 1);
        check("rst_out_imm", bi.out_imm, 0);
        check("rst_out_tag", bi.out_tag, 0);
        rst = 0;

        // Mode sweep
        cycle(1, 16'h8004, 0, 8'h10, 1, 0); check("sweep_m0", bi.out_imm, 32'hFFFF8004);
        cycle(1, 16'h8004, 1, 8'h11, 1, 0); check("sweep_m1", bi.out_imm, 32'h00008004);
        cycle(1, 16'h8004, 2, 8'h12, 1, 0); check("sweep_m2", bi.out_imm, 32'h80040000);
        cycle(1, 16'h8004, 3, 8'h13, 1, 0); check("sweep_m3", bi.out_imm, 32'hFFFE0010);
        cycle(1, 16'h7FFF, 3, 8'h14, 1, 0); check("sweep_br_pos", bi.out_imm, 32'h0001FFFC);
        check("sweep_tag", bi.out_tag, 8'h14);
        cycle(0, 0, 0, 0, 1, 0);
        check("sweep_drained", bi.out_valid, 0);

        // Back-pressure: tags 1..6, out_ready low in cycles 2..4
        next_tag  = 1;
        full_seen = 0;
        for (int c = 1; c <= 30 && popped.size() < 6; c++) begin
            logic ordy;
            logic v;
            ordy = !(c >= 2 && c <= 4);
            v    = (next_tag <= 6);
            if (occupancy == 2) begin
                full_seen++;
                check("bp_ready_low_full", bi.in_ready, 0);
            end
            if (bi.out_valid && ordy) popped.push_back(int'(bi.out_tag));
            if (v && bi.in_ready) begin
                cycle(1, 16'(next_tag), 1, 8'(next_tag), ordy, 0);
                next_tag++;
            end else begin
                cycle(v, 16'(next_tag), 1, 8'(next_tag), ordy, 0);
            end
        end
        check("bp_full_seen", full_seen > 0, 1);
        check("bp_count", popped.size(), 6);
        for (int i = 0; i < popped.size(); i++) check("bp_order", popped[i], i + 1);
        while (q_imm.size() > 0) cycle(0, 0, 0, 0, 1, 0);

        // Flush at occupancy 2 with in_valid and out_ready high
        cycle(1, 16'h0A01, 0, 8'h21, 0, 0);
        cycle(1, 16'h0A02, 0, 8'h22, 0, 0);
        check("fl_occ2", occupancy, 2);
        cycle(1, 16'h1234, 0, 8'hEE, 1, 1);
        check("fl_valid", bi.out_valid, 0);
        check("fl_occ0", occupancy, 0);
        check("fl_ready", bi.in_ready, 1);
        cycle(0, 0, 0, 0, 1, 0); check("fl_no_ghost1", bi.out_valid, 0);
        cycle(0, 0, 0, 0, 1, 0); check("fl_no_ghost2", bi.out_valid, 0);
        cycle(1, 16'h0033, 1, 8'h33, 1, 0); check("fl_resume_tag", bi.out_tag, 8'h33);
        cycle(0, 0, 0, 0, 1, 0);

        // Asynchronous reset between edges at occupancy 2
        cycle(1, 16'hBEEF, 0, 8'h51, 0, 0);
        cycle(1, 16'hCAFE, 0, 8'h52, 0, 0);
        check("ar_occ2", occupancy, 2);
        bi.in_valid = 0;
        #2;
        rst = 1;
        #1;
        check("ar_out_valid", bi.out_valid, 0);
        check("ar_occupancy", occupancy, 0);
        check("ar_in_ready", bi.in_ready, 1);
        check("ar_out_imm", bi.out_imm, 0);
        check("ar_out_tag", bi.out_tag, 0);
        q_imm.delete();
        q_tag.delete();
        @(negedge clk);
        rst = 0;
        cycle(1, 16'h0001, 0, 8'h44, 1, 0);
        check("ar_first_acc", bi.out_imm, 32'h00000001);
        cycle(0, 0, 0, 0, 1, 0);

        // Parameter variant 12 -> 20
        bi2.in_valid = 1; bi2.in_imm = 12'h800; bi2.in_mode = 0; bi2.in_tag = 8'h61;
        @(posedge clk); @(negedge clk);
        check("v_m0", bi2.out_imm, 20'hFF800);
        check("v_m0_model", bi2.out_imm, ref_ext(64'h800, 0, 12, 20));
        bi2.in_mode = 2; bi2.in_tag = 8'h62;
        @(posedge clk); @(negedge clk);
        check("v_m2", bi2.out_imm, 20'h80000);
        bi2.in_mode = 3; bi2.in_tag = 8'h63;
        @(posedge clk); @(negedge clk);
        check("v_m3", bi2.out_imm, 20'hFE000);
        check("v_tag", bi2.out_tag, 8'h63);
        bi2.in_valid = 0;
        @(posedge clk); @(negedge clk);
        check("v_drained", bi2.out_valid, 0);

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 1) == 1),
                  16'($urandom),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

- Registered, parametrised immediate-extension stage for the decode/execute boundary of the pipelined core.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI, branch offset.
- Carries a sideband tag with each immediate.
- A two-entry skid buffer with valid/ready handshakes lets execute-stage stalls back-pressure decode without a combinational ready path; a synchronous flush squashes in-flight entries on branch mispredict.

## Interface
Parameters:
- IN_W, 16, immediate input width (≥ 2)
- OUT_W, 32, extended output width (must be ≥ IN_W + 2)
- TAG_W, 8, sideband tag width (destination register/PC index), passed through unchanged

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all buffered entries
- in_valid  in  1  upstream presents an immediate
- in_ready  out  1  stage can accept; driven directly from a register
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  0 = sign-extend, 1 = zero-extend, 2 = upper, 3 = branch offset
- in_tag  in  TAG_W  sideband, travels with the immediate
- out_valid  out  1  out_imm/out_tag hold a valid entry
- out_ready  in  1  downstream accepts
- out_imm  out  OUT_W  extended immediate
- out_tag  out  TAG_W  tag of the presented entry
- occupancy  out  2  entries held (0–2)

## Operation
Extension is computed at the input, before registering:
- mode 0: {(OUT_W−IN_W){imm[IN_W−1]}, imm}
- mode 1: {(OUT_W−IN_W){0}, imm}
- mode 2: imm << (OUT_W−IN_W); low bits are 0. For 16→32 this is LUI.
- mode 3: sign-extend to OUT_W, then shift left 2. The top two bits of the sign-extended value are discarded; the constraint OUT_W ≥ IN_W+2 makes this lossless.

Storage:
- Main register M (drives outputs) and skid register S; each has a valid bit.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = !S.valid. It is registered, so it never depends on out_ready in the same cycle.
- out_valid = M.valid; occupancy = M.valid + S.valid.

Per-cycle update, no flush (order preserved, FIFO semantics):
- Pop and S.valid: M ← S; S ← accept ? new : empty.
- Pop, !S.valid: M ← accept ? new : empty.
- No pop, !M.valid: M ← accept ? new : empty.
- No pop, M.valid, !S.valid: S ← accept ? new : empty.
- No pop, both valid: no accept possible (in_ready = 0); hold.

Flush:
- Both valid bits clear next edge; an accept or pop in the same cycle is discarded.
- Next cycle: in_ready = 1, occupancy = 0.

Data hygiene:
- out_imm/out_tag change only when M loads.
- When M empties, data holds its last value; it is don't-care while out_valid = 0.

Reset (asynchronous, immediate): M.valid = S.valid = 0, out_imm = 0, out_tag = 0, in_ready = 1, occupancy = 0.

## Timing
- Latency: an accept at edge N gives out_valid = 1 after edge N; downstream can pop in the cycle following the accept.
- Throughput: 1 entry/cycle while out_ready = 1.
- Back-pressure: out_ready low for 1 cycle with continuous input fills S. in_ready falls the cycle after S fills and rises the cycle after S drains. No data loss, no duplication.
- Simultaneous accept + pop at occupancy 1: occupancy stays 1 and M takes new data.
- Simultaneous accept + pop at occupancy 2 cannot occur, because in_ready = 0.
- Reset asserted mid-transfer: outputs go to reset values asynchronously. The first accept is possible on the first edge after Reset deasserts.
- Flush has priority over all accepts and pops. Reset has priority over flush.

## Test plan
- Mode sweep, IN_W = 16, OUT_W = 32, out_ready = 1. Inputs: imm 0x8004 in modes 0/1/2/3 → out_imm 0xFFFF8004, 0x00008004, 0x80040000, 0xFFFE0010, each one cycle after accept. Also imm 0x7FFF mode 3 → 0x0001FFFC.
- Back-pressure: stream tags 1..6 continuously; hold out_ready = 0 for cycles 2–4. Expect in_ready = 0 while occupancy = 2, and output tag order exactly 1..6 with no gaps or repeats.
- Flush at occupancy 2, with in_valid = 1 and out_ready = 1 in that cycle. Next cycle: out_valid = 0, occupancy = 0, in_ready = 1. The entry offered during the flush cycle never appears.
- Asynchronous reset asserted between clock edges with occupancy 2. Expect outputs to drop to reset values before the next edge. After deassert, a new accept of imm 0x0001 mode 0 → 0x00000001.
- Parameter variant IN_W = 12, OUT_W = 20. Inputs: 0x800 mode 0 → 0xFF800; mode 2 → 0x80000; mode 3 → 0xFE000.
- Random soak: 10k cycles of random in_valid/out_ready/flush (flush at 2%), scoreboard-checked against a reference model. Every popped value must equal the model value; no accept occurs while in_ready = 0.
